// File: rtl/uart_param_system.sv
// uart_param_system: parameterised UART transmitter and receiver with a show-ahead RX FIFO.
module uart_param_system #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int BAUD_RATE     = 19200,
  parameter int DATA_WIDTH    = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  txByteStart,
  input  logic [DATA_WIDTH-1:0] byteForTx,
  output logic                  tx,
  output logic                  tx_ready,
  input  logic                  rx,
  input  logic                  rxByteRead,
  output logic [DATA_WIDTH-1:0] byteFromRx,
  output logic                  rx_new_byte_indicate,
  output logic                  rx_ready,
  output logic                  rx_frame_err,
  output logic                  rx_parity_err,
  output logic                  rx_overrun
);
  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(DIV + 1);
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [CW-1:0] bitEnd = CW'(DIV - 1);
  localparam logic [CW-1:0] halfEnd = CW'(DIV / 2 - 1);
  localparam logic [3:0] lastData = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] lastStop = 4'(STOP_BITS - 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PAR = 3'd3, STOP = 3'd4, WAIT_IDLE = 3'd5;

  function automatic logic parBit(input logic [DATA_WIDTH-1:0] d);
    return PARITY == 1 ? ~^d : ^d;
  endfunction

  logic [2:0] txState;
  logic [CW-1:0] txCnt;
  logic [3:0] txIdx;
  logic [DATA_WIDTH-1:0] txShift;
  logic txPar;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      txState <= IDLE;
      txCnt <= '0;
      txIdx <= '0;
      txShift <= '0;
      txPar <= 1'b0;
    end else if (txState == IDLE) begin
      txCnt <= '0;
      txIdx <= '0;
      if (txByteStart) begin
        txShift <= byteForTx;
        txPar <= parBit(byteForTx);
        txState <= START;
      end
    end else if (txCnt != bitEnd) begin
      txCnt <= txCnt + 1'b1;
    end else begin
      txCnt <= '0;
      case (txState)
        START: txState <= DATA;
        DATA: begin
          txShift <= txShift >> 1;
          txIdx <= txIdx == lastData ? 4'd0 : txIdx + 1'b1;
          if (txIdx == lastData) txState <= PARITY != 0 ? PAR : STOP;
        end
        PAR: txState <= STOP;
        default: begin
          txIdx <= txIdx == lastStop ? 4'd0 : txIdx + 1'b1;
          if (txIdx == lastStop) txState <= IDLE;
        end
      endcase
    end
  end

  assign tx = txState == START ? 1'b0 : txState == DATA ? txShift[0] : txState == PAR ? txPar : 1'b1;
  assign tx_ready = txState == IDLE;

  logic rxS1, rxS2, rxPrev;
  logic [2:0] rxState;
  logic [CW-1:0] rxCnt;
  logic [3:0] rxIdx;
  logic [DATA_WIDTH-1:0] rxShift;
  logic rxParErr, rxFrmErr;
  logic rxSample, frmNext, push;

  assign rxSample = rxCnt == (rxState == START ? halfEnd : bitEnd);
  assign frmNext = rxFrmErr | ~rxS2;
  assign push = rxState == STOP && rxSample && rxIdx == lastStop;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      {rxS1, rxS2, rxPrev} <= 3'b111;
      rxState <= IDLE;
      rxCnt <= '0;
      rxIdx <= '0;
      rxShift <= '0;
      rxParErr <= 1'b0;
      rxFrmErr <= 1'b0;
    end else begin
      {rxS1, rxS2, rxPrev} <= {rx, rxS1, rxS2};
      case (rxState)
        IDLE: begin
          rxCnt <= '0;
          rxIdx <= '0;
          rxParErr <= 1'b0;
          rxFrmErr <= 1'b0;
          if (rxPrev && !rxS2) rxState <= START;
        end
        WAIT_IDLE: if (rxS2) rxState <= IDLE;
        default:
          if (!rxSample) rxCnt <= rxCnt + 1'b1;
          else begin
            rxCnt <= '0;
            case (rxState)
              START: rxState <= rxS2 ? IDLE : DATA;
              DATA: begin
                rxShift <= {rxS2, rxShift[DATA_WIDTH-1:1]};
                rxIdx <= rxIdx == lastData ? 4'd0 : rxIdx + 1'b1;
                if (rxIdx == lastData) rxState <= PARITY != 0 ? PAR : STOP;
              end
              PAR: begin
                rxParErr <= rxS2 != parBit(rxShift);
                rxState <= STOP;
              end
              default: begin
                rxFrmErr <= frmNext;
                rxIdx <= rxIdx == lastStop ? 4'd0 : rxIdx + 1'b1;
                if (rxIdx == lastStop) rxState <= frmNext ? WAIT_IDLE : IDLE;
              end
            endcase
          end
      endcase
    end
  end

  assign rx_ready = rxState == IDLE;

  logic [EW-1:0] mem [RX_FIFO_DEPTH];
  logic [AW:0] wrPtr, rdPtr;
  logic empty, full, pop, wr;
  logic [EW-1:0] head;

  assign empty = wrPtr == rdPtr;
  assign full = wrPtr == {~rdPtr[AW], rdPtr[AW-1:0]};
  assign pop = rxByteRead && !empty;
  assign wr = push && (!full || pop);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (wr) wrPtr <= wrPtr + 1'b1;
      if (pop) rdPtr <= rdPtr + 1'b1;
      if (pop) rx_overrun <= 1'b0;
      else if (push && full) rx_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) if (wr) mem[wrPtr[AW-1:0]] <= {rxParErr, frmNext, rxShift};

  assign head = empty ? '0 : mem[rdPtr[AW-1:0]];
  assign {rx_parity_err, rx_frame_err, byteFromRx} = head;
  assign rx_new_byte_indicate = !empty;
endmodule
